// File: rtl/lsu_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding, alignment check.
package lsu_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_t;

  // Illegal width codes are folded into the alignment fault.
  function automatic logic access_fault(input logic [2:0] f3, input logic [1:0] alo);
    case (f3)
      F3_B, F3_BU: return 1'b0;
      F3_H, F3_HU: return alo[0];
      F3_W:        return alo != 2'b00;
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_unit_load_extend.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends it.
// Purely combinational; no backpressure.
module load_extend
  import lsu_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] ext_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[{addr_lo, 3'b000} +: 8];
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    ext_data = {{24{lane_b[7]}}, lane_b};
      F3_H:    ext_data = {{16{lane_h[15]}}, lane_h};
      F3_BU:   ext_data = {24'd0, lane_b};
      F3_HU:   ext_data = {16'd0, lane_h};
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit: one access at a time, done 1 cycle after mem_ack (misaligned: 1 cycle after accept).
// Stalls the core while busy; mem_req and all mem_* outputs held stable until mem_ack.
module lsu_unit
  import lsu_unit_pkg::*;
#(
  parameter int DLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [DLEN-1:0] addr,
  input  logic [DLEN-1:0] wdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [DLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [DLEN-1:0] mem_rdata,
  output logic [DLEN-1:0] ld_data,
  output logic            done,
  output logic            stall,
  output logic            misaligned
);

  lsu_state_t      state, state_nxt;
  logic            st_q;
  logic [2:0]      f3_q;
  logic [1:0]      alo_q;
  logic            mis_q;
  logic            fault;
  logic            accept;
  logic            take_ack;
  logic [3:0]      be_nxt;
  logic [DLEN-1:0] wdata_nxt;
  logic [DLEN-1:0] ext_data;

  always_comb begin
    fault = access_fault(funct3, addr[1:0]);
    case (funct3[1:0])
      2'b00: begin
        be_nxt    = 4'b0001 << addr[1:0];
        wdata_nxt = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_nxt    = 4'b0011 << addr[1:0];
        wdata_nxt = {2{wdata[15:0]}};
      end
      default: begin
        be_nxt    = 4'b1111;
        wdata_nxt = wdata;
      end
    endcase
  end

  assign accept   = (state == LSU_IDLE) && valid;
  assign take_ack = (state == LSU_REQ) && mem_ack;

  always_comb begin
    state_nxt = state;
    case (state)
      LSU_IDLE: if (valid) state_nxt = fault ? LSU_DONE : LSU_REQ;
      LSU_REQ:  if (mem_ack) state_nxt = LSU_DONE;
      LSU_DONE: state_nxt = LSU_IDLE;
      default:  state_nxt = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= LSU_IDLE;
      st_q      <= 1'b0;
      f3_q      <= 3'd0;
      alo_q     <= 2'd0;
      mis_q     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'd0;
      mem_wdata <= '0;
      ld_data   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        st_q      <= is_store;
        f3_q      <= funct3;
        alo_q     <= addr[1:0];
        mis_q     <= fault;
        mem_addr  <= {addr[DLEN-1:2], 2'b00};
        mem_be    <= be_nxt;
        mem_wdata <= wdata_nxt;
        mem_req   <= !fault;
        mem_we    <= is_store && !fault;
        if (fault) ld_data <= '0;
      end
      if (take_ack) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        ld_data <= st_q ? '0 : ext_data;
      end
    end
  end

  load_extend u_load_extend (
    .rdata    (mem_rdata),
    .funct3   (f3_q),
    .addr_lo  (alo_q),
    .ext_data (ext_data)
  );

  assign done       = (state == LSU_DONE);
  assign misaligned = done && mis_q;
  assign stall      = valid && (state != LSU_DONE);

endmodule

// File: tb/tb_lsu_unit.sv
// Directed testbench for lsu_unit with an inline memory responder.
module tb_lsu_unit;

  logic        clk = 1'b0;
  logic        rst_n, valid, is_store, mem_ack;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_rdata;
  logic        mem_req, mem_we, done, stall, misaligned;
  logic [31:0] mem_addr, mem_wdata, ld_data;
  logic [3:0]  mem_be;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]  o_be;
  logic [31:0] o_addr, o_wdata, o_ld;
  logic        o_we, o_mis, o_stall_ok, o_stable;
  int          o_lat, o_req;

  lsu_unit #(.DLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ld_data(ld_data), .done(done), .stall(stall), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one access and records what the DUT did; latency counts edges from accept to done.
  task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int waits);
    int wc;
    bit seen;
    wc = 0; seen = 0; o_lat = -1; o_req = 0; o_stall_ok = 1; o_stable = 1;
    o_be = '0; o_addr = '0; o_wdata = '0; o_we = 0; o_ld = '0; o_mis = 0;
    is_store = st; funct3 = f3; addr = a; wdata = wd; valid = 1; mem_ack = 0;
    #1;
    if (stall !== 1'b1) o_stall_ok = 0;
    for (int c = 1; c <= 40 && o_lat < 0; c++) begin
      tick;
      if (done === 1'b1) begin
        o_lat = c; o_ld = ld_data; o_mis = misaligned;
        if (stall !== 1'b0 || mem_req !== 1'b0) o_stall_ok = 0;
        mem_ack = 0;
      end else begin
        if (stall !== 1'b1) o_stall_ok = 0;
        if (mem_req === 1'b1) begin
          o_req++;
          if (!seen) begin
            o_be = mem_be; o_addr = mem_addr; o_wdata = mem_wdata; o_we = mem_we; seen = 1;
          end else if (mem_be !== o_be || mem_addr !== o_addr || mem_wdata !== o_wdata || mem_we !== o_we)
            o_stable = 0;
          if (wc == waits) begin mem_ack = 1; mem_rdata = rd; end
          else begin mem_ack = 0; wc++; end
        end
      end
    end
    valid = 0; mem_ack = 0;
    tick;
  endtask

  task test_reset;
    rst_n = 0; valid = 0; is_store = 0; funct3 = 3'b000; addr = '0; wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    tick; tick;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", mem_req); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b exp 0", mem_we); end
    n_checks++; if (done !== 1'b0 || misaligned !== 1'b0) begin n_fail++; $display("FAIL rst_done_mis got %b%b exp 00", done, misaligned); end
    n_checks++; if (mem_be !== 4'd0) begin n_fail++; $display("FAIL rst_be got %b exp 0000", mem_be); end
    n_checks++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin n_fail++; $display("FAIL rst_addr_wdata got %h %h exp 0 0", mem_addr, mem_wdata); end
    n_checks++; if (ld_data !== 32'd0) begin n_fail++; $display("FAIL rst_ld got %h exp 0", ld_data); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b exp 0", stall); end
    rst_n = 1;
    tick;
  endtask

  task test_lw;
    access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2);
    n_checks++; if (o_addr !== 32'h100) begin n_fail++; $display("FAIL lw_addr got %h exp 00000100", o_addr); end
    n_checks++; if (o_be !== 4'b1111) begin n_fail++; $display("FAIL lw_be got %b exp 1111", o_be); end
    n_checks++; if (o_we !== 1'b0) begin n_fail++; $display("FAIL lw_we got %b exp 0", o_we); end
    n_checks++; if (o_ld !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_ld got %h exp deadbeef", o_ld); end
    n_checks++; if (o_lat != 4 || o_req != 3) begin n_fail++; $display("FAIL lw_timing got lat %0d req %0d exp 4 3", o_lat, o_req); end
    n_checks++; if (!o_stall_ok || !o_stable) begin n_fail++; $display("FAIL lw_stall_stable got %0d %0d exp 1 1", o_stall_ok, o_stable); end
    n_checks++; if (done !== 1'b0 || ld_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_hold got done %b ld %h exp 0 deadbeef", done, ld_data); end
  endtask

  task test_byte;
    access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0);
    n_checks++; if (o_be !== 4'b1000) begin n_fail++; $display("FAIL lb_be got %b exp 1000", o_be); end
    n_checks++; if (o_addr !== 32'h100) begin n_fail++; $display("FAIL lb_addr got %h exp 00000100", o_addr); end
    n_checks++; if (o_ld !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_ld got %h exp ffffff80", o_ld); end
    n_checks++; if (o_lat != 2) begin n_fail++; $display("FAIL lb_lat got %0d exp 2", o_lat); end
    access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 1);
    n_checks++; if (o_ld !== 32'h00000080) begin n_fail++; $display("FAIL lbu_ld got %h exp 00000080", o_ld); end
    access(1'b0, 3'b000, 32'h101, 32'h0, 32'h80112233, 0);
    n_checks++; if (o_be !== 4'b0010 || o_ld !== 32'h00000022) begin n_fail++; $display("FAIL lb1 got be %b ld %h exp 0010 00000022", o_be, o_ld); end
  endtask

  task test_store;
    access(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h55555555, 0);
    n_checks++; if (o_we !== 1'b1) begin n_fail++; $display("FAIL sh_we got %b exp 1", o_we); end
    n_checks++; if (o_addr !== 32'h200) begin n_fail++; $display("FAIL sh_addr got %h exp 00000200", o_addr); end
    n_checks++; if (o_be !== 4'b1100) begin n_fail++; $display("FAIL sh_be got %b exp 1100", o_be); end
    n_checks++; if (o_wdata !== 32'hABCDABCD) begin n_fail++; $display("FAIL sh_wdata got %h exp abcdabcd", o_wdata); end
    n_checks++; if (o_ld !== 32'd0 || o_mis !== 1'b0) begin n_fail++; $display("FAIL sh_ld_mis got %h %b exp 0 0", o_ld, o_mis); end
    access(1'b1, 3'b000, 32'h201, 32'h000000EF, 32'h0, 0);
    n_checks++; if (o_be !== 4'b0010 || o_wdata !== 32'hEFEFEFEF) begin n_fail++; $display("FAIL sb got be %b wdata %h exp 0010 efefefef", o_be, o_wdata); end
  endtask

  task test_misaligned;
    access(1'b0, 3'b010, 32'h100, 32'h0, 32'h76543210, 0);
    access(1'b0, 3'b010, 32'h101, 32'h0, 32'h76543210, 0);
    n_checks++; if (o_req != 0) begin n_fail++; $display("FAIL mis_lw_req got %0d exp 0", o_req); end
    n_checks++; if (o_lat != 1 || o_mis !== 1'b1) begin n_fail++; $display("FAIL mis_lw got lat %0d mis %b exp 1 1", o_lat, o_mis); end
    n_checks++; if (o_ld !== 32'd0) begin n_fail++; $display("FAIL mis_lw_ld got %h exp 0", o_ld); end
    access(1'b0, 3'b101, 32'h301, 32'h0, 32'h0, 0);
    n_checks++; if (o_mis !== 1'b1 || o_req != 0) begin n_fail++; $display("FAIL mis_lhu got mis %b req %0d exp 1 0", o_mis, o_req); end
    access(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 0);
    n_checks++; if (o_mis !== 1'b1 || o_req != 0) begin n_fail++; $display("FAIL illegal_f3 got mis %b req %0d exp 1 0", o_mis, o_req); end
    access(1'b0, 3'b001, 32'h102, 32'h0, 32'h80112233, 0);
    n_checks++; if (o_mis !== 1'b0 || o_ld !== 32'hFFFF8011) begin n_fail++; $display("FAIL lh_hi got mis %b ld %h exp 0 ffff8011", o_mis, o_ld); end
  endtask

  task test_back_to_back;
    is_store = 0; funct3 = 3'b101; addr = 32'h302; wdata = 32'h0; valid = 1; mem_ack = 0;
    tick;
    n_checks++; if (mem_req !== 1'b1 || mem_be !== 4'b1100) begin n_fail++; $display("FAIL b2b_lhu_req got %b be %b exp 1 1100", mem_req, mem_be); end
    mem_ack = 1; mem_rdata = 32'h80011234;
    tick;
    mem_ack = 0;
    n_checks++; if (done !== 1'b1 || ld_data !== 32'h00008001) begin n_fail++; $display("FAIL b2b_lhu_done got %b ld %h exp 1 00008001", done, ld_data); end
    is_store = 1; funct3 = 3'b010; addr = 32'h304; wdata = 32'hCAFEF00D;
    tick;
    n_checks++; if (done !== 1'b0 || mem_req !== 1'b0 || stall !== 1'b1) begin n_fail++; $display("FAIL b2b_gap got done %b req %b stall %b exp 0 0 1", done, mem_req, stall); end
    tick;
    n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h304 || mem_be !== 4'b1111 || mem_wdata !== 32'hCAFEF00D)
      begin n_fail++; $display("FAIL b2b_sw_req got req %b we %b addr %h be %b wd %h", mem_req, mem_we, mem_addr, mem_be, mem_wdata); end
    mem_ack = 1;
    tick;
    mem_ack = 0;
    n_checks++; if (done !== 1'b1 || ld_data !== 32'd0) begin n_fail++; $display("FAIL b2b_sw_done got %b ld %h exp 1 0", done, ld_data); end
    valid = 0;
    tick;
  endtask

  task test_reset_mid;
    is_store = 0; funct3 = 3'b010; addr = 32'h400; valid = 1; mem_ack = 0;
    tick;
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_req got %b exp 1", mem_req); end
    rst_n = 0;
    tick;
    n_checks++; if (mem_req !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rmid_drop got req %b done %b exp 0 0", mem_req, done); end
    rst_n = 1; valid = 0; mem_ack = 1; mem_rdata = 32'h11111111;
    tick;
    n_checks++; if (done !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_late_ack got done %b req %b exp 0 0", done, mem_req); end
    tick;
    mem_ack = 0;
    n_checks++; if (done !== 1'b0 || ld_data !== 32'd0) begin n_fail++; $display("FAIL rmid_quiet got done %b ld %h exp 0 0", done, ld_data); end
    access(1'b0, 3'b010, 32'h10, 32'h0, 32'h00000055, 1);
    n_checks++; if (o_lat != 3 || o_ld !== 32'h55 || o_addr !== 32'h10) begin n_fail++; $display("FAIL rmid_restart got lat %0d ld %h addr %h exp 3 55 10", o_lat, o_ld, o_addr); end
  endtask

  initial begin
    test_reset;
    test_lw;
    test_byte;
    test_store;
    test_misaligned;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
- Load/store unit sitting directly upstream of the writeback select mux; its `ld_data` output drives the mux's memory-data input.
- Accepts one load or store from the core and issues a word-aligned request to data memory over a req/ack handshake.
- Generates byte enables, and sign/zero-extends load data per funct3.
- Holds the core stalled until the access completes.

Parameters:
- DLEN, 32, data/address width (fixed 32 for RV32; other values unsupported).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- valid  input  1  core presents a memory instruction this cycle.
- is_store  input  1  1 = store, 0 = load (qualified by valid).
- funct3  input  3  RV32 width/sign code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- addr  input  DLEN  effective byte address.
- wdata  input  DLEN  store data (rs2).
- mem_req  output  1  memory request, held until ack.
- mem_we  output  1  1 = write.
- mem_addr  output  DLEN  word address {addr[31:2],2'b00}.
- mem_be  output  4  byte enables.
- mem_wdata  output  DLEN  store data shifted into byte lanes.
- mem_ack  input  1  memory completes access this cycle.
- mem_rdata  input  DLEN  read word, valid with mem_ack.
- ld_data  output  DLEN  extended load result to writeback mux.
- done  output  1  one-cycle completion pulse.
- stall  output  1  hold PC/pipeline.
- misaligned  output  1  alignment fault flag, valid with done.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE.
  - mem_req, mem_we, done and misaligned are 0.
  - mem_be=0; mem_addr, mem_wdata and ld_data are 0.
  - Reset mid-access drops mem_req at that edge; a late mem_ack is ignored.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - On valid=1, latch is_store, funct3, addr[1:0] and the shifted wdata.
  - Misaligned access: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0. On this, go to DONE with misaligned=1 and no memory request.
  - Illegal funct3 (011,110,111) is treated as misaligned.
  - Otherwise go to REQ.
- REQ:
  - mem_req=1 and all mem_* outputs are registered and stable until ack.
  - mem_ack while in REQ captures mem_rdata, then go to DONE.
  - Wait is unbounded; mem_ack outside REQ is ignored.
- DONE:
  - done=1 for exactly one cycle, with ld_data and misaligned valid. Next state is IDLE.
  - ld_data holds its value until the next DONE.
- Byte enables:
  - Byte: 4'b0001<<addr[1:0].
  - Half: 4'b0011<<addr[1:0].
  - Word: 4'b1111.
- Store data: mem_wdata = wdata replicated per lane.
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata.
- Load data:
  - Select lane by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Store and misaligned: ld_data=0.
- stall = valid & (state!=DONE), combinational.
  - The core keeps valid and its inputs stable while stall=1.
  - New valid is accepted only in IDLE.
- Latency:
  - Aligned access: done at ack cycle+1; minimum 3 cycles (IDLE→REQ→DONE with ack in the first REQ cycle).
  - Misaligned access: done 2 cycles after valid.
- Back-to-back: valid may stay high after DONE. The next instruction is accepted in the following IDLE cycle; the core advances on done.

Decomposition:
- Shared package holds:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encoding LSU_IDLE/LSU_REQ/LSU_DONE.
- One natural sub-module: load_extend, combinational. Inputs rdata, funct3, addr[1:0]; output extended word. It is reused by any future cache path.
- Byte-enable/store-shift logic stays inline.

Test Plan:
- LW at addr 0x100, mem_rdata=0xDEADBEEF, ack after 2 wait cycles → mem_addr=0x100, mem_be=4'b1111, mem_we=0, ld_data=0xDEADBEEF, done 1 cycle, stall high until done.
- LB at 0x103 with rdata=0x80112233 → mem_be=4'b1000, ld_data=0xFFFFFF80. LBU same → 0x00000080.
- SH at 0x202 with wdata=0x1234ABCD → mem_we=1, mem_addr=0x200, mem_be=4'b1100, mem_wdata=0xABCDABCD, ld_data=0.
- LW at 0x101 → no mem_req ever asserted, done and misaligned=1 two cycles after valid.
- Reset asserted while in REQ before ack → next cycle mem_req=0, done never pulses. A subsequent ack is ignored; the next valid starts cleanly.
- Back-to-back LHU 0x302 (rdata=0x8001xxxx) then SW 0x304 with ack in the first REQ cycle → ld_data=0x00008001, two done pulses 3 cycles apart, mem_req deasserted between them.
